// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, pool FSM states and signed max helper.
// Imported by the simpleCNN pooling stage and its line buffer.
package cnn_pkg;

  localparam int POOL_DATA_W = 69;
  localparam int POOL_LANES  = 8;

  // Compare width; lane samples are sign-extended to this first.
  localparam int SMAX_W = 128;

  typedef enum logic [1:0] {
    S_TOP,
    S_BOT,
    S_SKIP
  } pool_state_t;

  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_linebuf.sv
// pool_linebuf: one entry per column pair, 1 write + 1 async read port.
// Ports: clk, wr_en/wr_addr/wr_data, rd_addr -> rd_data (same cycle).
module pool_linebuf #(
  parameter int DEPTH = 13,
  parameter int AW    = 4,
  parameter int W     = 552
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2/stride-2 max-pool, LANES channels wide.
// Ports: clk, rst (sync, active-low), in_valid/in_ready/in_sof/in_data,
// out_valid/out_ready/out_data/out_last, frame_done.
// POOL_FRAME_CNT_EN adds frame_cnt[15:0], counting frame_done pulses.
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int LANES  = POOL_LANES,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    frame_done
`ifdef POOL_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int BW = LANES * DATA_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = IMG_W / 2;
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_OUT = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_OUT = RW'(2 * (IMG_H / 2) - 1);
  localparam bit            H_ODD   = (IMG_H % 2) == 1;

  pool_state_t       state;
  pool_state_t       est;
  pool_state_t       nst;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     ecol;
  logic [RW-1:0]     erow;
  logic [RW-1:0]     nrow;
  logic [BW-1:0]     prev;
  logic [BW-1:0]     lb_rd;
  logic [BW-1:0]     pair_max;
  logic [BW-1:0]     tri_max;
  logic [AW-1:0]     lb_addr;
  logic              accept;
  logic              lb_wr;
  logic              emit;

  assign in_ready   = !(out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign frame_done = out_valid && out_ready && out_last;

  // A start-of-frame beat is processed as pixel (0,0) of a fresh frame.
  assign ecol = in_sof ? '0 : col;
  assign erow = in_sof ? '0 : row;
  assign est  = in_sof ? S_TOP : state;
  assign nrow = (erow == ROW_END) ? '0 : erow + RW'(1);

  always_comb begin
    nst = S_TOP;
    if (nrow[0]) begin
      nst = S_BOT;
    end else if (H_ODD && nrow == ROW_END) begin
      nst = S_SKIP;
    end
  end

  assign lb_addr = AW'(ecol >> 1);
  assign lb_wr   = accept && est == S_TOP && ecol[0];
  assign emit    = accept && est == S_BOT && ecol[0];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [SMAX_W-1:0] cur_x;
    logic signed [SMAX_W-1:0] prv_x;
    logic signed [SMAX_W-1:0] lb_x;
    logic signed [SMAX_W-1:0] pm_x;
    assign cur_x = SMAX_W'($signed(in_data[k*DATA_W +: DATA_W]));
    assign prv_x = SMAX_W'($signed(prev[k*DATA_W +: DATA_W]));
    assign lb_x  = SMAX_W'($signed(lb_rd[k*DATA_W +: DATA_W]));
    assign pair_max[k*DATA_W +: DATA_W] = DATA_W'(smax(prv_x, cur_x));
    assign pm_x  = SMAX_W'($signed(pair_max[k*DATA_W +: DATA_W]));
    assign tri_max[k*DATA_W +: DATA_W] = DATA_W'(smax(lb_x, pm_x));
  end

  pool_linebuf #(
    .DEPTH(PW),
    .AW   (AW),
    .W    (BW)
  ) u_linebuf (
    .clk    (clk),
    .wr_en  (lb_wr),
    .wr_addr(lb_addr),
    .wr_data(pair_max),
    .rd_addr(lb_addr),
    .rd_data(lb_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_TOP;
      col       <= '0;
      row       <= '0;
      prev      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        prev <= in_data;
        if (ecol == COL_END) begin
          col   <= '0;
          row   <= nrow;
          state <= nst;
        end else begin
          col   <= ecol + CW'(1);
          row   <= erow;
          state <= est;
        end
      end
      // A new result only arrives when in_ready, so reloading never
      // overwrites an unaccepted beat.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= tri_max;
        out_last  <= (erow == ROW_OUT) && (ecol == COL_OUT);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef POOL_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: scoreboard bench for the 2x2 max-pool stage.
// Drives a 4x4 and a 5x5 instance; POOL_FRAME_CNT_EN also checks frame_cnt.
module tb_maxpool2x2_stream;

  localparam int DW = 69;
  localparam int LN = 8;
  localparam int BW = DW * LN;

  typedef logic signed [DW-1:0] s_t;
  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel = 1'b0;
  logic          iv = 1'b0;
  logic          isof = 1'b0;
  logic [BW-1:0] idata = '0;
  logic          ordy = 1'b1;

  logic          o4_ready, o4_valid, o4_last, o4_done;
  logic          o5_ready, o5_valid, o5_last, o5_done;
  logic [BW-1:0] o4_data, o5_data;
  logic          m_ready, m_valid, m_last, m_done;
  logic [BW-1:0] m_data;
`ifdef POOL_FRAME_CNT_EN
  logic [15:0]   fc4, fc5;
`endif

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [BW-1:0] got[$];
  logic [BW-1:0] fm[5][5];
  exp_t          mon_e;

  always #5 clk = ~clk;

  assign m_ready = sel ? o5_ready : o4_ready;
  assign m_valid = sel ? o5_valid : o4_valid;
  assign m_last  = sel ? o5_last  : o4_last;
  assign m_done  = sel ? o5_done  : o4_done;
  assign m_data  = sel ? o5_data  : o4_data;

  maxpool2x2_stream #(
    .DATA_W(DW), .LANES(LN), .IMG_W(4), .IMG_H(4)
  ) u4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv && !sel),
    .in_ready  (o4_ready),
    .in_sof    (isof),
    .in_data   (idata),
    .out_valid (o4_valid),
    .out_ready (ordy),
    .out_data  (o4_data),
    .out_last  (o4_last),
    .frame_done(o4_done)
`ifdef POOL_FRAME_CNT_EN
    ,
    .frame_cnt (fc4)
`endif
  );

  maxpool2x2_stream #(
    .DATA_W(DW), .LANES(LN), .IMG_W(5), .IMG_H(5)
  ) u5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv && sel),
    .in_ready  (o5_ready),
    .in_sof    (isof),
    .in_data   (idata),
    .out_valid (o5_valid),
    .out_ready (ordy),
    .out_data  (o5_data),
    .out_last  (o5_last),
    .frame_done(o5_done)
`ifdef POOL_FRAME_CNT_EN
    ,
    .frame_cnt (fc5)
`endif
  );

  function automatic logic [BW-1:0] gen(
    input int mode, input int r, input int c, input int w
  );
    logic [BW-1:0] g;
    s_t            v;
    int            base;
    base = r * w + c;
    g = '0;
    for (int k = 0; k < LN; k++) begin
      case (mode)
        0: v = (k % 2 == 1) ? DW'(-base * (k + 1)) : DW'(base * (k + 1));
        1: v = (k == 7 && r == 1 && c == 1) ? DW'(-1) : DW'(-3);
        default: v = DW'(100 + base);
      endcase
      g[k*DW +: DW] = v;
    end
    return g;
  endfunction

  function automatic logic [BW-1:0] win_max(input int r, input int c);
    logic [BW-1:0] m;
    s_t            a, b, x, y, best;
    m = '0;
    for (int k = 0; k < LN; k++) begin
      a = fm[r-1][c-1][k*DW +: DW];
      b = fm[r-1][c][k*DW +: DW];
      x = fm[r][c-1][k*DW +: DW];
      y = fm[r][c][k*DW +: DW];
      best = a;
      if (b > best) best = b;
      if (x > best) best = x;
      if (y > best) best = y;
      m[k*DW +: DW] = best;
    end
    return m;
  endfunction

  task automatic send_beat(input logic [BW-1:0] d, input logic sof);
    int n;
    n = 0;
    iv = 1'b1;
    idata = d;
    isof = sof;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ready && n < 200);
    if (!m_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got %b want 1", m_ready);
    end
    @(posedge clk);
    #1;
    iv = 1'b0;
    isof = 1'b0;
  endtask

  task automatic send_frame(
    input int w, input int h, input int mode, input int nb, input logic push
  );
    int   r, c;
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      r = i / w;
      c = i % w;
      fm[r][c] = gen(mode, r, c, w);
      if (push && r % 2 == 1 && c % 2 == 1 &&
          r < 2 * (h / 2) && c < 2 * (w / 2)) begin
        e.data = win_max(r, c);
        e.last = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
        sb.push_back(e);
      end
      send_beat(fm[r][c], i == 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
  endtask

  task automatic check_lane0(input string nm, input int idx, input int want);
    logic [BW-1:0] t;
    s_t            g;
    checks++;
    if (idx >= got.size()) begin
      errors++;
      $display("FAIL %s missing out %0d got %0d outs", nm, idx, got.size());
    end else begin
      t = got[idx];
      g = t[DW-1:0];
      if (g !== DW'(want)) begin
        errors++;
        $display("FAIL %s out%0d lane0 got %0d want %0d", nm, idx, g, want);
      end
    end
  endtask

  task automatic check_count(input string nm, input int want);
    checks++;
    if (got.size() != want) begin
      errors++;
      $display("FAIL %s count got %0d want %0d", nm, got.size(), want);
    end
  endtask

  always @(negedge clk) begin
    if (rst && m_valid && ordy) begin
      got.push_back(m_data);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h", m_data);
      end else begin
        mon_e = sb.pop_front();
        if (m_data !== mon_e.data || m_last !== mon_e.last) begin
          errors++;
          $display("FAIL out_beat got %h/%b want %h/%b",
                   m_data, m_last, mon_e.data, mon_e.last);
        end
        checks++;
        if (m_done !== mon_e.last) begin
          errors++;
          $display("FAIL frame_done got %b want %b", m_done, mon_e.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o4_valid, o4_last, o4_done, o5_valid, o5_last, o5_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0",
               {o4_valid, o4_last, o4_done, o5_valid, o5_last, o5_done});
    end
    checks++;
    if (o4_data !== '0 || o5_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", o4_data);
    end
    checks++;
    if (o4_ready !== 1'b1 || o5_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 11", o4_ready, o5_ready);
    end
`ifdef POOL_FRAME_CNT_EN
    checks++;
    if (fc4 !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %0d want 0", fc4);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    got.delete();
    send_frame(4, 4, 0, 16, 1'b1);
    drain();
    check_count("basic", 4);
    check_lane0("basic", 0, 5);
    check_lane0("basic", 1, 7);
    check_lane0("basic", 2, 13);
    check_lane0("basic", 3, 15);
  endtask

  task automatic test_signed();
    logic [BW-1:0] t;
    s_t            g7, g0;
    got.delete();
    send_frame(4, 4, 1, 16, 1'b1);
    drain();
    check_count("signed", 4);
    t = (got.size() > 0) ? got[0] : '0;
    g7 = t[7*DW +: DW];
    g0 = t[DW-1:0];
    checks++;
    if (g7 !== DW'(-1) || g0 !== DW'(-3)) begin
      errors++;
      $display("FAIL signed lane7/lane0 got %0d/%0d want -1/-3", g7, g0);
    end
  endtask

  task automatic test_back_pressure();
    got.delete();
    fork
      send_frame(4, 4, 0, 16, 1'b1);
      begin
        int   n;
        s_t   g;
        n = 0;
        while (!m_valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        ordy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          g = m_data[DW-1:0];
          checks++;
          if (m_ready !== 1'b0 || m_valid !== 1'b1 || g !== DW'(5)) begin
            errors++;
            $display("FAIL hold rdy/vld/data got %b/%b/%0d want 0/1/5",
                     m_ready, m_valid, g);
          end
        end
        @(posedge clk);
        #1;
        ordy = 1'b1;
      end
    join
    drain();
    check_count("backpressure", 4);
    check_lane0("backpressure", 0, 5);
    check_lane0("backpressure", 1, 7);
    check_lane0("backpressure", 2, 13);
    check_lane0("backpressure", 3, 15);
  endtask

  task automatic test_odd_dims();
    sel = 1'b1;
    got.delete();
    send_frame(5, 5, 0, 25, 1'b1);
    drain();
    check_count("odd5x5", 4);
    check_lane0("odd5x5", 0, 6);
    check_lane0("odd5x5", 1, 8);
    check_lane0("odd5x5", 2, 16);
    check_lane0("odd5x5", 3, 18);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    ordy = 1'b0;
    send_frame(4, 4, 0, 6, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o4_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid got %b want 0", o4_valid);
    end
    rst = 1'b1;
    ordy = 1'b1;
    got.delete();
    send_frame(4, 4, 0, 16, 1'b1);
    drain();
    check_count("midreset", 4);
    check_lane0("midreset", 0, 5);
    check_lane0("midreset", 3, 15);
  endtask

  task automatic test_sof_restart();
`ifdef POOL_FRAME_CNT_EN
    logic [15:0] fcb;
    fcb = fc4;
`endif
    got.delete();
    send_frame(4, 4, 2, 9, 1'b1);
    send_frame(4, 4, 0, 16, 1'b1);
    drain();
    check_count("sof", 6);
    check_lane0("sof", 0, 105);
    check_lane0("sof", 1, 107);
    check_lane0("sof", 2, 5);
    check_lane0("sof", 3, 7);
    check_lane0("sof", 4, 13);
    check_lane0("sof", 5, 15);
`ifdef POOL_FRAME_CNT_EN
    checks++;
    if (fc4 !== fcb + 16'd1) begin
      errors++;
      $display("FAIL frame_cnt got %0d want %0d", fc4, fcb + 16'd1);
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_pressure();
    test_odd_dims();
    test_reset_mid();
    test_sof_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
